// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - retirement trace capture: classify, stamp and buffer commits
// First-word fall-through FIFO drained through a valid/ready record port.
module commit_trace_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 16,
   parameter int REG_W  = 3,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cm_valid,
   input  logic [DATA_W-1:0] cm_pc,
   input  logic [DATA_W-1:0] cm_inst,
   input  logic              cm_reg_we,
   input  logic [REG_W-1:0]  cm_reg_sel,
   input  logic [DATA_W-1:0] cm_reg_data,
   input  logic              cm_mem_rd,
   input  logic              cm_mem_wr,
   input  logic [DATA_W-1:0] cm_mem_addr,
   input  logic [DATA_W-1:0] cm_mem_data,
   input  logic              cm_halt,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic [2:0]        rec_kind,
   output logic [CNT_W-1:0]  rec_inum,
   output logic [CNT_W-1:0]  rec_cycle,
   output logic [DATA_W-1:0] rec_pc,
   output logic [DATA_W-1:0] rec_inst,
   output logic [DATA_W-1:0] rec_reg_data,
   output logic [DATA_W-1:0] rec_addr,
   output logic [DATA_W-1:0] rec_mem_data,
   output logic [REG_W-1:0]  rec_reg_sel,
   output logic              full,
   output logic              overflow,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic              halted
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [2:0] K_NOP = 3'd0, K_REG = 3'd1, K_LD = 3'd2,
                          K_ST = 3'd3, K_STU = 3'd4, K_HALT = 3'd5;
   localparam logic [CNT_W-1:0] C_ONE = 1;
   localparam logic [AW:0]      P_ONE = 1;

   logic [2:0]        r_kind     [DEPTH];
   logic [CNT_W-1:0]  r_inum     [DEPTH];
   logic [CNT_W-1:0]  r_cycle    [DEPTH];
   logic [DATA_W-1:0] r_pc       [DEPTH];
   logic [DATA_W-1:0] r_inst     [DEPTH];
   logic [DATA_W-1:0] r_reg_data [DEPTH];
   logic [DATA_W-1:0] r_addr     [DEPTH];
   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic [REG_W-1:0]  r_reg_sel  [DEPTH];

   logic [AW:0]       r_wptr, r_rptr;
   logic [CNT_W-1:0]  r_cycle_cnt, r_inum_cnt, r_drop_cnt;
   logic              r_overflow, r_capture_done, r_halted;

   logic              w_empty, w_full, w_pop, w_req, w_push, w_drop;
   logic [2:0]        w_kind;
   logic [AW-1:0]     w_waddr, w_raddr;

   assign w_waddr = r_wptr[AW-1:0];
   assign w_raddr = r_rptr[AW-1:0];
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_waddr == w_raddr);
   assign w_pop   = ~w_empty & rec_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign w_req   = cm_valid & ~r_capture_done;
   assign w_push  = w_req & (~w_full | w_pop);
   assign w_drop  = w_req & w_full & ~w_pop;

   always_comb begin
      w_kind = K_NOP;
      if (cm_halt)                     w_kind = K_HALT;
      else if (cm_reg_we && cm_mem_wr) w_kind = K_STU;
      else if (cm_reg_we && cm_mem_rd) w_kind = K_LD;
      else if (cm_reg_we)              w_kind = K_REG;
      else if (cm_mem_wr)              w_kind = K_ST;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_kind[i]     <= '0;
            r_inum[i]     <= '0;
            r_cycle[i]    <= '0;
            r_pc[i]       <= '0;
            r_inst[i]     <= '0;
            r_reg_data[i] <= '0;
            r_addr[i]     <= '0;
            r_mem_data[i] <= '0;
            r_reg_sel[i]  <= '0;
         end
      end else if (w_push) begin
         r_kind[w_waddr]     <= w_kind;
         r_inum[w_waddr]     <= r_inum_cnt;
         r_cycle[w_waddr]    <= r_cycle_cnt;
         r_pc[w_waddr]       <= cm_pc;
         r_inst[w_waddr]     <= cm_inst;
         r_reg_data[w_waddr] <= cm_reg_data;
         r_addr[w_waddr]     <= cm_mem_addr;
         r_mem_data[w_waddr] <= cm_mem_data;
         r_reg_sel[w_waddr]  <= cm_reg_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_cycle_cnt    <= '0;
         r_inum_cnt     <= '0;
         r_drop_cnt     <= '0;
         r_overflow     <= 1'b0;
         r_capture_done <= 1'b0;
         r_halted       <= 1'b0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + C_ONE;
         // Dropped commits still consume an instruction number
         if (w_req)  r_inum_cnt <= r_inum_cnt + C_ONE;
         if (w_push) r_wptr <= r_wptr + P_ONE;
         if (w_pop)  r_rptr <= r_rptr + P_ONE;
         if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= r_drop_cnt + C_ONE;
         end
         if (w_push && w_kind == K_HALT) r_capture_done <= 1'b1;
         if (w_pop && r_kind[w_raddr] == K_HALT) r_halted <= 1'b1;
      end
   end

   assign rec_valid    = ~w_empty;
   assign rec_kind     = r_kind[w_raddr];
   assign rec_inum     = r_inum[w_raddr];
   assign rec_cycle    = r_cycle[w_raddr];
   assign rec_pc       = r_pc[w_raddr];
   assign rec_inst     = r_inst[w_raddr];
   assign rec_reg_data = r_reg_data[w_raddr];
   assign rec_addr     = r_addr[w_raddr];
   assign rec_mem_data = r_mem_data[w_raddr];
   assign rec_reg_sel  = r_reg_sel[w_raddr];
   assign full         = w_full;
   assign overflow     = r_overflow;
   assign drop_cnt     = r_drop_cnt;
   assign halted       = r_halted;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb/tb_commit_trace_fifo.sv - directed self-checking bench for commit_trace_fifo
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_commit_trace_fifo;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cm_valid = 1'b0;
   logic [15:0] cm_pc = '0, cm_inst = '0, cm_reg_data = '0, cm_mem_addr = '0, cm_mem_data = '0;
   logic        cm_reg_we = 1'b0, cm_mem_rd = 1'b0, cm_mem_wr = 1'b0, cm_halt = 1'b0;
   logic [2:0]  cm_reg_sel = '0;
   logic        rec_ready = 1'b0;
   logic        rec_valid, full, overflow, halted;
   logic [2:0]  rec_kind, rec_reg_sel;
   logic [31:0] rec_inum, rec_cycle, drop_cnt;
   logic [15:0] rec_pc, rec_inst, rec_reg_data, rec_addr, rec_mem_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   commit_trace_fifo #(.DEPTH(DEPTH), .DATA_W(16), .REG_W(3), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
      .cm_reg_we(cm_reg_we), .cm_reg_sel(cm_reg_sel), .cm_reg_data(cm_reg_data),
      .cm_mem_rd(cm_mem_rd), .cm_mem_wr(cm_mem_wr), .cm_mem_addr(cm_mem_addr),
      .cm_mem_data(cm_mem_data), .cm_halt(cm_halt), .rec_valid(rec_valid),
      .rec_ready(rec_ready), .rec_kind(rec_kind), .rec_inum(rec_inum), .rec_cycle(rec_cycle),
      .rec_pc(rec_pc), .rec_inst(rec_inst), .rec_reg_data(rec_reg_data), .rec_addr(rec_addr),
      .rec_mem_data(rec_mem_data), .rec_reg_sel(rec_reg_sel), .full(full),
      .overflow(overflow), .drop_cnt(drop_cnt), .halted(halted)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   // kind: 0 NOP, 1 REG, 2 LD, 3 ST, 4 STU, 5 HALT
   task automatic commit(input int kind, input logic [15:0] pc, input logic [2:0] sel,
                         input logic [15:0] rdata, input logic [15:0] addr, input logic [15:0] mdata);
      cm_valid    = 1'b1;
      cm_pc       = pc;
      cm_inst     = pc ^ 16'hA5A5;
      cm_reg_sel  = sel;
      cm_reg_data = rdata;
      cm_mem_addr = addr;
      cm_mem_data = mdata;
      cm_halt     = (kind == 5);
      cm_reg_we   = (kind == 1 || kind == 2 || kind == 4);
      cm_mem_rd   = (kind == 2);
      cm_mem_wr   = (kind == 3 || kind == 4);
   endtask

   task automatic idle();
      cm_valid = 1'b0; cm_halt = 1'b0; cm_reg_we = 1'b0; cm_mem_rd = 1'b0; cm_mem_wr = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rec_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      tick();
      n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", rec_valid); end
      n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %0b want 0", full); end
      n_cmp++; if (overflow !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL reset_flags got ovf=%0b halt=%0b want 0 0", overflow, halted); end
      n_cmp++; if (drop_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
      n_cmp++; if (rec_inum !== 32'd0 || rec_cycle !== 32'd0 || rec_pc !== 16'd0 || rec_reg_data !== 16'd0)
         begin n_bad++; $display("FAIL reset_data got inum=%0d cyc=%0d pc=%h rd=%h want 0", rec_inum, rec_cycle, rec_pc, rec_reg_data); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_reg();
      do_reset();
      rec_ready = 1'b1;
      commit(1, 16'h0000, 3'd3, 16'h1234, 16'h0000, 16'h0000);
      tick();
      idle();
      n_cmp++; if (rec_valid !== 1'b1 || rec_kind !== 3'd1) begin n_bad++; $display("FAIL reg_head got v=%0b kind=%0d want 1 1", rec_valid, rec_kind); end
      n_cmp++; if (rec_inum !== 32'd0 || rec_cycle !== 32'd0) begin n_bad++; $display("FAIL reg_stamp got inum=%0d cyc=%0d want 0 0", rec_inum, rec_cycle); end
      n_cmp++; if (rec_reg_sel !== 3'd3 || rec_reg_data !== 16'h1234) begin n_bad++; $display("FAIL reg_fields got sel=%0d data=%h want 3 1234", rec_reg_sel, rec_reg_data); end
      tick();
      n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL reg_drained got %0b want 0", rec_valid); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_kind [4];
      exp_kind[0] = 3'd3; exp_kind[1] = 3'd2; exp_kind[2] = 3'd4; exp_kind[3] = 3'd0;
      do_reset();
      rec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         commit(int'(exp_kind[i]), 16'h0100 + 16'(i), 3'd1, 16'h0055, 16'h0010, 16'hBEEF);
         tick();
         n_cmp++; if (rec_valid !== 1'b1 || rec_kind !== exp_kind[i] || rec_inum !== 32'(i) || rec_cycle !== 32'(i))
            begin n_bad++; $display("FAIL b2b_%0d got v=%0b kind=%0d inum=%0d cyc=%0d want 1 %0d %0d %0d",
                                    i, rec_valid, rec_kind, rec_inum, rec_cycle, exp_kind[i], i, i); end
         n_cmp++; if (rec_addr !== 16'h0010 || rec_mem_data !== 16'hBEEF || rec_pc !== 16'h0100 + 16'(i))
            begin n_bad++; $display("FAIL b2b_fields_%0d got addr=%h md=%h pc=%h want 0010 beef %h", i, rec_addr, rec_mem_data, rec_pc, 16'h0100 + 16'(i)); end
      end
      idle();
      tick();
      n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %0b want 0", rec_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH + 2; i++) begin
         commit(1, 16'(i), 3'd2, 16'(i), 16'h0, 16'h0);
         tick();
         if (i == DEPTH - 1) begin
            n_cmp++; if (full !== 1'b1 || overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_full got full=%0b ovf=%0b want 1 0", full, overflow); end
         end
      end
      idle();
      n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 32'd2 || full !== 1'b1)
         begin n_bad++; $display("FAIL ovf_flags got ovf=%0b drop=%0d full=%0b want 1 2 1", overflow, drop_cnt, full); end
      rec_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++; if (rec_valid !== 1'b1 || rec_inum !== 32'(i) || rec_pc !== 16'(i))
            begin n_bad++; $display("FAIL ovf_drain_%0d got v=%0b inum=%0d pc=%h want 1 %0d %h", i, rec_valid, rec_inum, rec_pc, i, 16'(i)); end
         tick();
      end
      n_cmp++; if (rec_valid !== 1'b0 || full !== 1'b0) begin n_bad++; $display("FAIL ovf_after got v=%0b full=%0b want 0 0", rec_valid, full); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         commit(1, 16'(i), 3'd4, 16'h0, 16'h0, 16'h0);
         tick();
      end
      rec_ready = 1'b1;
      commit(3, 16'h0100, 3'd0, 16'h0, 16'h0020, 16'h1111);
      tick();
      idle();
      n_cmp++; if (full !== 1'b1 || drop_cnt !== 32'd0 || overflow !== 1'b0)
         begin n_bad++; $display("FAIL fpp_flags got full=%0b drop=%0d ovf=%0b want 1 0 0", full, drop_cnt, overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++; if (rec_valid !== 1'b1 || rec_inum !== 32'(i + 1))
            begin n_bad++; $display("FAIL fpp_drain_%0d got v=%0b inum=%0d want 1 %0d", i, rec_valid, rec_inum, i + 1); end
         if (i == DEPTH - 1) begin
            n_cmp++; if (rec_pc !== 16'h0100 || rec_kind !== 3'd3)
               begin n_bad++; $display("FAIL fpp_last got pc=%h kind=%0d want 0100 3", rec_pc, rec_kind); end
         end
         tick();
      end
      n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_empty got %0b want 0", rec_valid); end
   endtask

   task automatic test_halt();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         commit(i < 5 ? 0 : (i == 5 ? 5 : 1), 16'(i), 3'd0, 16'h0, 16'h0, 16'h0);
         tick();
      end
      idle();
      n_cmp++; if (drop_cnt !== 32'd0 || overflow !== 1'b0 || full !== 1'b0)
         begin n_bad++; $display("FAIL halt_nodrop got drop=%0d ovf=%0b full=%0b want 0 0 0", drop_cnt, overflow, full); end
      rec_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_cmp++; if (rec_valid !== 1'b1 || rec_inum !== 32'(i) || rec_kind !== (i == 5 ? 3'd5 : 3'd0) || halted !== 1'b0)
            begin n_bad++; $display("FAIL halt_rec_%0d got v=%0b inum=%0d kind=%0d halted=%0b want 1 %0d %0d 0",
                                    i, rec_valid, rec_inum, rec_kind, halted, i, (i == 5 ? 5 : 0)); end
         tick();
      end
      n_cmp++; if (halted !== 1'b1 || rec_valid !== 1'b0) begin n_bad++; $display("FAIL halt_done got halted=%0b v=%0b want 1 0", halted, rec_valid); end
      commit(1, 16'h0077, 3'd1, 16'h0, 16'h0, 16'h0);
      tick();
      idle();
      n_cmp++; if (rec_valid !== 1'b0 || drop_cnt !== 32'd0 || halted !== 1'b1)
         begin n_bad++; $display("FAIL halt_ignore got v=%0b drop=%0d halted=%0b want 0 0 1", rec_valid, drop_cnt, halted); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         commit(1, 16'h0040 + 16'(i), 3'd5, 16'h00AA, 16'h0, 16'h0);
         tick();
      end
      idle();
      tick();
      n_cmp++; if (rec_valid !== 1'b1 || rec_cycle === 32'd0 && rec_inum === 32'd0 && rec_pc !== 16'h0040)
         begin n_bad++; $display("FAIL arst_pre got v=%0b pc=%h want 1 0040", rec_valid, rec_pc); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (rec_valid !== 1'b0 || rec_pc !== 16'h0 || rec_reg_data !== 16'h0 || drop_cnt !== 32'd0)
         begin n_bad++; $display("FAIL arst_now got v=%0b pc=%h rd=%h drop=%0d want 0 0 0 0", rec_valid, rec_pc, rec_reg_data, drop_cnt); end
      tick();
      rst_n = 1'b1;
      rec_ready = 1'b1;
      commit(1, 16'h0900, 3'd6, 16'h0001, 16'h0, 16'h0);
      tick();
      idle();
      n_cmp++; if (rec_valid !== 1'b1 || rec_inum !== 32'd0 || rec_cycle !== 32'd0 || rec_pc !== 16'h0900)
         begin n_bad++; $display("FAIL arst_post got v=%0b inum=%0d cyc=%0d pc=%h want 1 0 0 0900", rec_valid, rec_inum, rec_cycle, rec_pc); end
      tick();
   endtask

   initial begin
      tick();
      test_reset();
      test_single_reg();
      test_back_to_back();
      test_overflow();
      test_full_push_pop();
      test_halt();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
